// File: rtl/alu_multicycle.sv
// alu_multicycle: execution stage performing ADD, SUB, OR, SLL and SRL under a start/done
// handshake. ADD/SUB/OR and illegal codes complete in one cycle. Shifts iterate one bit per
// cycle unless ALU_BARREL_SHIFT_EN is defined, in which case they use a combinational barrel
// shifter and also complete in one cycle (busy_o then never asserts).
module alu_multicycle #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SHAMT_WIDTH = 5   // must equal clog2(DATA_WIDTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_i,
  input  logic [3:0]             alu_operation_i,
  input  logic [DATA_WIDTH-1:0]  a_i,
  input  logic [DATA_WIDTH-1:0]  b_i,
  input  logic [SHAMT_WIDTH-1:0] shamt_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [DATA_WIDTH-1:0]  result_o,
  output logic                   zero_o,
  output logic                   illegal_op_o
);

  localparam logic [3:0] OpOr  = 4'b0001;
  localparam logic [3:0] OpSll = 4'b0010;
  localparam logic [3:0] OpAdd = 4'b0011;
  localparam logic [3:0] OpSub = 4'b0100;
  localparam logic [3:0] OpSrl = 4'b0101;

`ifdef ALU_BARREL_SHIFT_EN
  localparam bit Iterative = 1'b0;
`else
  localparam bit Iterative = 1'b1;
`endif

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e                 state_q;
  logic [DATA_WIDTH-1:0]  shift_q;
  logic                   shift_left_q;
  logic [SHAMT_WIDTH-1:0] cnt_q;

  logic                   is_shift;
  logic                   illegal_op;
  logic [DATA_WIDTH-1:0]  imm_result;
  logic [DATA_WIDTH-1:0]  shift_step;

  // Single-cycle result for the op presented in IDLE; illegal codes yield zero.
  always_comb begin
    imm_result = '0;
    illegal_op = 1'b0;
    is_shift   = 1'b0;
    case (alu_operation_i)
      OpAdd: imm_result = a_i + b_i;
      OpSub: imm_result = a_i - b_i;
      OpOr:  imm_result = a_i | b_i;
      OpSll: begin
        is_shift = 1'b1;
`ifdef ALU_BARREL_SHIFT_EN
        imm_result = b_i << shamt_i;
`else
        // Only used when shamt_i is zero; nonzero amounts go through the SHIFT state.
        imm_result = b_i;
`endif
      end
      OpSrl: begin
        is_shift = 1'b1;
`ifdef ALU_BARREL_SHIFT_EN
        imm_result = b_i >> shamt_i;
`else
        imm_result = b_i;
`endif
      end
      default: illegal_op = 1'b1;
    endcase
  end

  // One-bit step of the iterative shifter, zero fill in both directions.
  always_comb begin
    shift_step = shift_left_q ? (shift_q << 1) : (shift_q >> 1);
  end

  // Control FSM with registered outputs; done_o is a one-cycle pulse after each completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      shift_q      <= '0;
      shift_left_q <= 1'b0;
      cnt_q        <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      result_o     <= '0;
      zero_o       <= 1'b1;
      illegal_op_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start_i) begin
            if (Iterative && is_shift && (shamt_i != '0)) begin
              shift_q      <= b_i;
              shift_left_q <= (alu_operation_i == OpSll);
              cnt_q        <= shamt_i;
              busy_o       <= 1'b1;
              state_q      <= StShift;
            end else begin
              result_o     <= imm_result;
              zero_o       <= (imm_result == '0);
              illegal_op_o <= illegal_op;
              done_o       <= 1'b1;
            end
          end
        end
        StShift: begin
          shift_q <= shift_step;
          cnt_q   <= cnt_q - SHAMT_WIDTH'(1);
          if (cnt_q == SHAMT_WIDTH'(1)) begin
            result_o     <= shift_step;
            zero_o       <= (shift_step == '0);
            illegal_op_o <= 1'b0;
            done_o       <= 1'b1;
            busy_o       <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed steps, expected results queued on issue
// and compared when done_o pulses. Honours ALU_BARREL_SHIFT_EN for latency expectations.
module tb_alu_multicycle;

`ifdef ALU_BARREL_SHIFT_EN
  localparam bit Iter = 1'b0;
`else
  localparam bit Iter = 1'b1;
`endif

  localparam logic [3:0] OpOr  = 4'b0001;
  localparam logic [3:0] OpSll = 4'b0010;
  localparam logic [3:0] OpAdd = 4'b0011;
  localparam logic [3:0] OpSub = 4'b0100;
  localparam logic [3:0] OpSrl = 4'b0101;

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op_in = 4'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic [4:0]  sh_in = '0;
  logic        busy, done, zero, illegal;
  logic [31:0] result;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  logic [31:0] prev_res = '0;

  always #5 clk = ~clk;

  alu_multicycle #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
    .clk             (clk),
    .reset           (reset),
    .start_i         (start),
    .alu_operation_i (op_in),
    .a_i             (a_in),
    .b_i             (b_in),
    .shamt_i         (sh_in),
    .busy_o          (busy),
    .done_o          (done),
    .result_o        (result),
    .zero_o          (zero),
    .illegal_op_o    (illegal)
  );

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, b,
                                 input logic [4:0] sh);
    exp_t e;
    e.ill = 1'b0;
    case (op)
      OpAdd:   e.res = a + b;
      OpSub:   e.res = a - b;
      OpOr:    e.res = a | b;
      OpSll:   e.res = b << sh;
      OpSrl:   e.res = b >> sh;
      default: begin e.res = 32'h0; e.ill = 1'b1; end
    endcase
    e.zero = (e.res == 32'h0);
    return e;
  endfunction

  function automatic int exp_latency(input logic [3:0] op, input logic [4:0] sh);
    if (Iter && (op == OpSll || op == OpSrl) && sh != 5'd0) return int'(sh) + 1;
    return 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Pop the oldest expected entry and compare against the registered outputs.
  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_res"},  result,        e.res);
      chk({tag, "_zero"}, 32'(zero),     32'(e.zero));
      chk({tag, "_ill"},  32'(illegal),  32'(e.ill));
      prev_res = e.res;
    end
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, b, input logic [4:0] sh,
                        input string tag, input bit intrude);
    int lat;
    int busy_cnt;
    int extra;
    int exp_lat;
    exp_lat = exp_latency(op, sh);
    sb.push_back(model(op, a, b, sh));
    @(negedge clk);
    start = 1'b1; op_in = op; a_in = a; b_in = b; sh_in = sh;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    busy_cnt = 0;
    while (!done && lat < 200) begin
      if (busy) busy_cnt++;
      if (lat == 2) chk({tag, "_held"}, result, prev_res);
      if (intrude && lat == 2) begin
        start = 1'b1; op_in = OpAdd; a_in = 32'h1; b_in = 32'h1; sh_in = 5'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_busy"}, 32'(busy_cnt), 32'(exp_lat - 1));
    if (done) check_out(tag);
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(done), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    if (intrude) begin
      extra = 0;
      repeat (4) begin
        @(negedge clk);
        if (done) extra++;
      end
      chk({tag, "_nodone"}, 32'(extra), 32'd0);
    end
  endtask

  initial begin
    int dones;
    // Reset values, checked while reset is held.
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_res",  result, 32'h0);
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_ill",  32'(illegal), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op(OpAdd, 32'h0000_0005, 32'h0000_0007, 5'd0, "add", 1'b0);
    run_op(OpSub, 32'h1234_5678, 32'h1234_5678, 5'd0, "sub_eq", 1'b0);
    run_op(OpSub, 32'h0000_0000, 32'h0000_0001, 5'd0, "sub_wrap", 1'b0);
    run_op(OpAdd, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, "add_wrap", 1'b0);
    run_op(OpSll, 32'hDEAD_BEEF, 32'h0000_0001, 5'd31, "sll31", 1'b0);
    run_op(OpSrl, 32'h0, 32'h8000_0000, 5'd4, "srl4", Iter);
    run_op(OpSll, 32'h0, 32'h0000_ABCD, 5'd0, "sll0", 1'b0);
    run_op(OpSrl, 32'h0, 32'hF000_000F, 5'd1, "srl1", 1'b0);
    run_op(OpSll, 32'h0, 32'h0F0F_0001, 5'd7, "sll7", 1'b0);
    run_op(4'b1001, 32'h5, 32'h6, 5'd0, "illegal", 1'b0);
    run_op(OpOr, 32'h0000_00F0, 32'h0000_000F, 5'd0, "or", 1'b0);
    run_op(4'b1111, 32'h1, 32'h1, 5'd0, "illegal2", 1'b0);
    run_op(OpSrl, 32'h0, 32'h0000_0010, 5'd5, "srl_zero", 1'b0);

    // Back-to-back: second start issued in the done_o cycle of the first.
    sb.push_back(model(OpAdd, 32'd10, 32'd20, 5'd0));
    sb.push_back(model(OpOr, 32'h100, 32'h1, 5'd0));
    @(negedge clk);
    start = 1'b1; op_in = OpAdd; a_in = 32'd10; b_in = 32'd20; sh_in = 5'd0;
    @(negedge clk);
    chk("b2b_done1", 32'(done), 32'd1);
    check_out("b2b_add");
    op_in = OpOr; a_in = 32'h100; b_in = 32'h1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_done2", 32'(done), 32'd1);
    check_out("b2b_or");
    @(negedge clk);
    chk("b2b_pulse", 32'(done), 32'd0);

    // Reset mid-shift: no completion, outputs back to reset values.
    @(negedge clk);
    start = 1'b1; op_in = OpSll; a_in = 32'h0; b_in = 32'h3; sh_in = 5'd20;
    dones = 0;
    repeat (5) begin
      @(negedge clk);
      start = 1'b0;
      if (done) dones++;
    end
    chk("rstmid_nodone", 32'(dones), Iter ? 32'd0 : 32'd1);
    reset = 1'b1;
    #1;
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_done", 32'(done), 32'd0);
    chk("rstmid_res",  result, 32'h0);
    chk("rstmid_zero", 32'(zero), 32'd1);
    chk("rstmid_ill",  32'(illegal), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    prev_res = 32'h0;
    dones = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("rstmid_after", 32'(dones), 32'd0);
    run_op(OpAdd, 32'd2, 32'd3, 5'd0, "add_after_rst", 1'b0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
